// File: rtl/accel_pkg.sv
// Shared accelerator definitions: default datapath widths and the
// requantised output entry carried through the output FIFO.
package accel_pkg;

  localparam int WIDTH_ACC_DEF = 40;
  localparam int WIDTH_OUT_DEF = 16;

  // One FIFO word as seen by the output collector; packs as {data, sat}.
  typedef struct packed {
    logic [WIDTH_OUT_DEF-1:0] data;
    logic                     sat;
  } rq_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with an exported occupancy count.
// The caller guarantees no write when full without a pop and no pop when
// empty; a simultaneous write and pop is legal at any fill level.
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               count_q, count_d;

  // Next-state: pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    if (wr_en) mem_d[wr_ptr_q] = wr_data;
  end

  // Storage and pointer registers; reset discards all contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head is forced to zero when empty so nothing stale is ever presented.
  assign rd_valid = (count_q != '0);
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;

endmodule

// File: rtl/pe_requant.sv
// Requantisation stage behind a PE: round-half-up right shift of the
// accumulator, unsigned saturation to the output width, and a credit-gated
// output FIFO so that an accepted accumulator is never dropped.
module pe_requant
  import accel_pkg::*;
#(
  parameter int WIDTH_ACC = WIDTH_ACC_DEF,
  parameter int WIDTH_OUT = WIDTH_OUT_DEF,
  parameter int DEPTH     = 4,
  parameter int SHIFT_W   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH_ACC-1:0] in_acc,
  output logic                 in_ready,
  input  logic [SHIFT_W-1:0]   shift,
  output logic                 out_valid,
  output logic [WIDTH_OUT-1:0] out_data,
  output logic                 out_sat,
  input  logic                 out_ready,
  output logic [15:0]          sat_count
);

  localparam int SUM_W = WIDTH_ACC + 1;            // keeps the rounding carry
  localparam int CSH_W = $clog2(WIDTH_ACC + 1);    // holds 0..WIDTH_ACC
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int CR_W  = CNT_W + 1;                // count + two stage valids

  logic                 acc_fire;
  logic [1:0]           vld_pipe_q, vld_pipe_d;    // [0]=S1, [1]=S2
  logic [CSH_W-1:0]     sh_clamp;
  logic [SUM_W-1:0]     rnd;
  logic [SUM_W-1:0]     s1_sum_q, s1_sum_d;
  logic [CSH_W-1:0]     s1_sh_q, s1_sh_d;
  logic [SUM_W-1:0]     r;
  logic                 r_ovf;
  logic [WIDTH_OUT-1:0] s2_data_q, s2_data_d;
  logic                 s2_sat_q, s2_sat_d;
  logic [15:0]          sat_count_q, sat_count_d;
  logic                 fifo_wr, fifo_rd;
  logic [WIDTH_OUT:0]   fifo_head;
  logic [CNT_W-1:0]     fifo_count;
  logic [CR_W-1:0]      credits_used;

  // Credits cover every word that could still land in the FIFO, so the
  // pipeline never needs to stall. Purely register-derived on purpose.
  assign credits_used = CR_W'(fifo_count) + CR_W'(vld_pipe_q[0]) + CR_W'(vld_pipe_q[1]);
  assign in_ready     = ~rst & (credits_used < CR_W'(DEPTH));
  assign acc_fire     = in_valid & in_ready;

  // S1: clamp the shift and add the half-LSB rounding constant.
  always_comb begin
    if (32'(shift) > WIDTH_ACC) sh_clamp = CSH_W'(WIDTH_ACC);
    else                        sh_clamp = CSH_W'(shift);
    rnd      = (sh_clamp == '0) ? '0 : (SUM_W'(1) << (sh_clamp - CSH_W'(1)));
    s1_sum_d = acc_fire ? ({1'b0, in_acc} + rnd) : s1_sum_q;
    s1_sh_d  = acc_fire ? sh_clamp : s1_sh_q;
  end

  // S2: shift down and saturate to the unsigned output range.
  always_comb begin
    r         = s1_sum_q >> s1_sh_q;
    r_ovf     = |r[SUM_W-1:WIDTH_OUT];
    s2_data_d = s2_data_q;
    s2_sat_d  = s2_sat_q;
    if (vld_pipe_q[0]) begin
      s2_data_d = r_ovf ? '1 : r[WIDTH_OUT-1:0];
      s2_sat_d  = r_ovf;
    end
  end

  // Valid shift register and sticky-at-max saturation counter.
  always_comb begin
    vld_pipe_d  = {vld_pipe_q[0], acc_fire};
    sat_count_d = sat_count_q;
    if (fifo_wr && s2_sat_q && (sat_count_q != 16'hFFFF))
      sat_count_d = sat_count_q + 16'd1;
  end

  // Pipeline registers; reset drops anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q  <= '0;
      s1_sum_q    <= '0;
      s1_sh_q     <= '0;
      s2_data_q   <= '0;
      s2_sat_q    <= 1'b0;
      sat_count_q <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      s1_sum_q    <= s1_sum_d;
      s1_sh_q     <= s1_sh_d;
      s2_data_q   <= s2_data_d;
      s2_sat_q    <= s2_sat_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign fifo_wr = vld_pipe_q[1];
  assign fifo_rd = out_valid & out_ready;

  sync_fifo #(
    .WIDTH (WIDTH_OUT + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (fifo_wr),
    .wr_data  ({s2_data_q, s2_sat_q}),
    .rd_en    (fifo_rd),
    .rd_data  (fifo_head),
    .rd_valid (out_valid),
    .count    (fifo_count)
  );

  assign out_data  = fifo_head[WIDTH_OUT:1];
  assign out_sat   = fifo_head[0];
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_pe_requant.sv
// Self-checking bench for pe_requant: directed scenarios plus a randomized
// run, scored against an arithmetic model of round/shift/saturate.
module tb_pe_requant;
  import accel_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [39:0] in_acc;
  logic        in_ready;
  logic [5:0]  shift;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_sat;
  logic        out_ready;
  logic [15:0] sat_count;

  int total = 0;
  int bad   = 0;

  rq_entry_t exp_q[$];
  rq_entry_t got_q[$];
  int        exp_idx = 0;
  int        got_idx = 0;
  logic      ovf_seen = 1'b0;

  always #5 clk = ~clk;

  pe_requant #(.WIDTH_ACC(40), .WIDTH_OUT(16), .DEPTH(DEPTH), .SHIFT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_acc    (in_acc),
    .in_ready  (in_ready),
    .shift     (shift),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_ready (out_ready),
    .sat_count (sat_count)
  );

  // Reference: plain 64-bit arithmetic of round-half-up shift then clamp.
  function automatic rq_entry_t model(input logic [39:0] acc, input logic [5:0] sh);
    rq_entry_t       e;
    int              s;
    longint unsigned sum, r;
    s   = (sh > 6'd40) ? 40 : int'(sh);
    sum = 64'(acc) + ((s > 0) ? (64'd1 << (s - 1)) : 64'd0);
    r   = sum >> s;
    if (r > 64'd65535) begin e.data = 16'hFFFF; e.sat = 1'b1; end
    else begin e.data = r[15:0]; e.sat = 1'b0; end
    return e;
  endfunction

  // Observer: records accepts (as model results) and pops; watches FIFO bounds.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) exp_q.push_back(model(in_acc, shift));
      if (out_valid && out_ready) got_q.push_back({out_data, out_sat});
      if (int'(dut.u_fifo.count) > DEPTH) ovf_seen <= 1'b1;
      if (dut.fifo_wr && int'(dut.u_fifo.count) == DEPTH && !(out_valid && out_ready)) ovf_seen <= 1'b1;
      if (dut.fifo_rd && dut.u_fifo.count == '0) ovf_seen <= 1'b1;
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_acc = '0; shift = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 16'd0) begin bad++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
    total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL reset_out_sat: got %b want 0", out_sat); end
    total++; if (sat_count !== 16'd0) begin bad++; $display("FAIL reset_sat_count: got %0d want 0", sat_count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_hi: got %b want 0", in_ready); end
    tick(); rst = 1'b0; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_rel: got %b want 1", in_ready); end
    tick();
  endtask

  task automatic test_rounding;
    out_ready = 1'b1;
    in_valid = 1'b1; in_acc = 40'd735; shift = 6'd0;
    tick(); shift = 6'd1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rnd_lat1: got %b want 0", out_valid); end
    tick(); shift = 6'd2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rnd_lat2: got %b want 0", out_valid); end
    tick(); in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rnd_lat3: got %b want 1", out_valid); end
    total++; if ({out_data, out_sat} !== {16'd735, 1'b0}) begin bad++; $display("FAIL rnd_sh0: got %0d/%b want 735/0", out_data, out_sat); end
    tick();
    total++; if ({out_data, out_sat} !== {16'd368, 1'b0}) begin bad++; $display("FAIL rnd_sh1: got %0d/%b want 368/0", out_data, out_sat); end
    tick();
    total++; if ({out_data, out_sat} !== {16'd184, 1'b0}) begin bad++; $display("FAIL rnd_sh2: got %0d/%b want 184/0", out_data, out_sat); end
    for (int c = 0; c < 40 && (got_q.size() - got_idx) < (exp_q.size() - exp_idx); c++) tick();
    while (got_idx < got_q.size() && exp_idx < exp_q.size()) begin
      total++;
      if (got_q[got_idx] !== exp_q[exp_idx]) begin bad++; $display("FAIL rnd_sb: got %h want %h", got_q[got_idx], exp_q[exp_idx]); end
      got_idx++; exp_idx++;
    end
    tick();
  endtask

  task automatic test_saturation;
    out_ready = 1'b1;
    in_valid = 1'b1; in_acc = 40'd1 << 20; shift = 6'd0;
    tick(); shift = 6'd5;
    tick(); in_valid = 1'b0;
    tick();
    total++; if ({out_data, out_sat} !== {16'hFFFF, 1'b1}) begin bad++; $display("FAIL sat_hi: got %h/%b want ffff/1", out_data, out_sat); end
    total++; if (sat_count !== 16'd1) begin bad++; $display("FAIL sat_cnt1: got %0d want 1", sat_count); end
    tick();
    total++; if ({out_data, out_sat} !== {16'd32768, 1'b0}) begin bad++; $display("FAIL sat_sh5: got %0d/%b want 32768/0", out_data, out_sat); end
    total++; if (sat_count !== 16'd1) begin bad++; $display("FAIL sat_cnt_hold: got %0d want 1", sat_count); end
    for (int c = 0; c < 40 && (got_q.size() - got_idx) < (exp_q.size() - exp_idx); c++) tick();
    while (got_idx < got_q.size() && exp_idx < exp_q.size()) begin
      total++;
      if (got_q[got_idx] !== exp_q[exp_idx]) begin bad++; $display("FAIL sat_sb: got %h want %h", got_q[got_idx], exp_q[exp_idx]); end
      got_idx++; exp_idx++;
    end
    tick();
  endtask

  task automatic test_clamp;
    out_ready = 1'b1;
    in_valid = 1'b1; in_acc = {40{1'b1}}; shift = 6'd63;
    tick(); shift = 6'd40;
    tick(); shift = 6'd41;
    tick(); in_valid = 1'b0;
    total++; if ({out_data, out_sat} !== {16'd1, 1'b0}) begin bad++; $display("FAIL clamp_carry: got %0d/%b want 1/0", out_data, out_sat); end
    for (int c = 0; c < 40 && (got_q.size() - got_idx) < (exp_q.size() - exp_idx); c++) tick();
    while (got_idx < got_q.size() && exp_idx < exp_q.size()) begin
      total++;
      if (got_q[got_idx] !== exp_q[exp_idx]) begin bad++; $display("FAIL clamp_sb: got %h want %h", got_q[got_idx], exp_q[exp_idx]); end
      got_idx++; exp_idx++;
    end
    tick();
  endtask

  // Holds values 1..6 on the input, advancing only after an accept.
  int bp_v, bp_n;
  task automatic bp_cycles(input int n);
    logic took;
    for (int k = 0; k < n; k++) begin
      @(negedge clk); took = in_valid && in_ready;
      if (took) bp_n++;
      tick();
      if (took) begin bp_v++; in_valid = (bp_v <= 6); in_acc = 40'(bp_v); end
    end
  endtask

  task automatic test_back_pressure;
    out_ready = 1'b0; shift = 6'd0;
    bp_v = 1; bp_n = 0; in_acc = 40'd1; in_valid = 1'b1;
    bp_cycles(8);
    total++; if (bp_n !== 4) begin bad++; $display("FAIL bp_accepts4: got %0d want 4", bp_n); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
    total++; if ({out_valid, out_data} !== {1'b1, 16'd1}) begin bad++; $display("FAIL bp_head1: got %b/%0d want 1/1", out_valid, out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_pop_same_cycle: got %b want 0", in_ready); end
    tick(); out_ready = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_pop_next_cycle: got %b want 1", in_ready); end
    total++; if (out_data !== 16'd2) begin bad++; $display("FAIL bp_head2: got %0d want 2", out_data); end
    bp_cycles(4);
    total++; if (bp_n !== 5) begin bad++; $display("FAIL bp_accepts5: got %0d want 5", bp_n); end
    out_ready = 1'b1;
    bp_cycles(6);
    total++; if (bp_n !== 6) begin bad++; $display("FAIL bp_accepts6: got %0d want 6", bp_n); end
    in_valid = 1'b0;
    for (int c = 0; c < 40 && (got_q.size() - got_idx) < (exp_q.size() - exp_idx); c++) tick();
    total++; if (got_q.size() - got_idx !== 6) begin bad++; $display("FAIL bp_count: got %0d want 6", got_q.size() - got_idx); end
    for (int i = 0; got_idx < got_q.size() && exp_idx < exp_q.size(); i++) begin
      total++;
      if (got_q[got_idx] !== exp_q[exp_idx] || got_q[got_idx].data !== 16'(i + 1)) begin
        bad++; $display("FAIL bp_order: got %h want %h (value %0d)", got_q[got_idx], exp_q[exp_idx], i + 1);
      end
      got_idx++; exp_idx++;
    end
    tick();
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    for (int k = 0; k < 22; k++) begin
      in_valid = (k < 16);
      in_acc   = 40'({$urandom, $urandom}) >> $urandom_range(16, 39);
      shift    = 6'($urandom_range(0, 8));
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, in_ready); end
      total++; if (out_valid !== (k >= 3 && k <= 18)) begin bad++; $display("FAIL b2b_valid[%0d]: got %b want %b", k, out_valid, (k >= 3 && k <= 18)); end
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 40 && (got_q.size() - got_idx) < (exp_q.size() - exp_idx); c++) tick();
    while (got_idx < got_q.size() && exp_idx < exp_q.size()) begin
      total++;
      if (got_q[got_idx] !== exp_q[exp_idx]) begin bad++; $display("FAIL b2b_sb: got %h want %h", got_q[got_idx], exp_q[exp_idx]); end
      got_idx++; exp_idx++;
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_acc    = 40'({$urandom, $urandom}) >> $urandom_range(0, 40);
      shift     = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 20)) : 6'($urandom_range(0, 63));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 40 && (got_q.size() - got_idx) < (exp_q.size() - exp_idx); c++) tick();
    total++; if ((got_q.size() - got_idx) !== (exp_q.size() - exp_idx)) begin bad++; $display("FAIL rnd_drain: got %0d words want %0d", got_q.size() - got_idx, exp_q.size() - exp_idx); end
    while (got_idx < got_q.size() && exp_idx < exp_q.size()) begin
      total++;
      if (got_q[got_idx] !== exp_q[exp_idx]) begin bad++; $display("FAIL rand_sb: got %h want %h", got_q[got_idx], exp_q[exp_idx]); end
      got_idx++; exp_idx++;
    end
    tick();
  endtask

  task automatic test_mid_reset;
    out_ready = 1'b0; shift = 6'd0; in_acc = 40'd1 << 20; in_valid = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mrst_pre_valid: got %b want 1", out_valid); end
    rst = 1'b1; #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_out_valid: got %b want 0", out_valid); end
    total++; if (sat_count !== 16'd0) begin bad++; $display("FAIL mrst_sat_count: got %0d want 0", sat_count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mrst_in_ready_hi: got %b want 0", in_ready); end
    tick(); rst = 1'b0; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mrst_in_ready_rel: got %b want 1", in_ready); end
    exp_idx = exp_q.size(); got_idx = got_q.size();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_stale[%0d]: got %b want 0", k, out_valid); end
      tick();
    end
    in_valid = 1'b1; in_acc = 40'd1 << 20;
    tick(); in_valid = 1'b0;
    for (int c = 0; c < 40 && (got_q.size() - got_idx) < (exp_q.size() - exp_idx); c++) tick();
    total++; if (got_q.size() - got_idx !== 1) begin bad++; $display("FAIL mrst_post_count: got %0d want 1", got_q.size() - got_idx); end
    while (got_idx < got_q.size() && exp_idx < exp_q.size()) begin
      total++;
      if (got_q[got_idx] !== exp_q[exp_idx]) begin bad++; $display("FAIL mrst_sb: got %h want %h", got_q[got_idx], exp_q[exp_idx]); end
      got_idx++; exp_idx++;
    end
    total++; if (sat_count !== 16'd1) begin bad++; $display("FAIL mrst_sat_restart: got %0d want 1", sat_count); end
    total++; if (ovf_seen !== 1'b0) begin bad++; $display("FAIL fifo_bounds: got %b want 0", ovf_seen); end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_clamp();
    test_back_pressure();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
